proc_test_sequencer: RTL and testbench
======================================

Name: proc_test_sequencer

Overview:
Synthesizable run controller for the single-cycle `processor`. It runs a table of NUM_PROGS programs back to back. For each program it resets the core at that program's start PC and waits until `currentpc` reaches the end PC. It then lets the pipeline settle, compares `WB_data` against the expected pass code and tallies the result. A per-program watchdog aborts runaway programs. The block replaces bench-only sequencing, so FPGA/self-check builds and multi-program regressions run without a testbench.

Parameters:
NUM_PROGS, 4, number of programs in the table (≥1)
PC_W, 64, PC width
DATA_W, 64, WB data / pass-code width
WD_W, 16, watchdog counter width
WD_LIMIT, 16'h0020, cycles in RUN before timeout (≥1, < 2^WD_W)
RESET_CYCLES, 1, cycles `proc_resetl` is held low per program (≥1)
SETTLE_CYCLES, 1, cycles after end-PC hit before sampling `wb_data` (≥0)

Ports:
Clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; begins sequence from IDLE
prog_startpc  in  NUM_PROGS*PC_W  packed start PCs, program i at [i*PC_W +: PC_W]
prog_endpc  in  NUM_PROGS*PC_W  packed end PCs
prog_expect  in  NUM_PROGS*DATA_W  packed expected pass codes
currentpc  in  PC_W  from processor
wb_data  in  DATA_W  from processor `WB_data`
proc_resetl  out  1  to processor `resetl` (active-low)
proc_startpc  out  PC_W  to processor `startpc`
busy  out  1  high in any state except IDLE/DONE/TIMEOUT
result_valid  out  1  one-cycle pulse per checked program
result_pass  out  1  valid with result_valid
result_idx  out  $clog2(NUM_PROGS)+1  program index of result
pass_count  out  $clog2(NUM_PROGS)+1  running passes
done  out  1  sticky, all programs checked
all_passed  out  1  sticky, done && pass_count==NUM_PROGS
timeout  out  1  sticky watchdog expiry
timeout_idx  out  $clog2(NUM_PROGS)+1  program that timed out

Behaviour:
- Reset (sync, reset=1 at edge) → state IDLE.
- Reset values: proc_resetl=0, proc_startpc=0, busy=0, result_*=0, pass_count=0, done=0, all_passed=0, timeout=0, timeout_idx=0, idx=0, wd=0.
- Reset mid-operation aborts immediately to these values. No partial result is emitted.
- States: IDLE, RST, RUN, SETTLE, CHECK, DONE, TIMEOUT. All outputs are registered.
- IDLE: proc_resetl=0. If start=1, go to RST with idx=0.
- RST:
  - proc_resetl=0, proc_startpc=prog_startpc[idx], wd cleared.
  - Hold RESET_CYCLES cycles, then go to RUN. proc_resetl=1 from the first RUN cycle.
- RUN:
  - wd increments each cycle.
  - If currentpc ≥ prog_endpc[idx] (unsigned), go to SETTLE, or directly to CHECK when SETTLE_CYCLES=0.
  - Else if wd == WD_LIMIT-1, go to TIMEOUT.
  - End-PC hit and watchdog expiry in the same cycle: end-PC wins.
- SETTLE: count SETTLE_CYCLES cycles with the processor still running, then go to CHECK.
- CHECK (1 cycle):
  - result_valid=1, result_idx=idx, result_pass=(wb_data==prog_expect[idx]).
  - pass_count increments on pass.
  - If idx==NUM_PROGS-1, go to DONE. Else idx+1 and go to RST.
- DONE: done=1; all_passed=(pass_count==NUM_PROGS); proc_resetl=0. Terminal until reset.
- TIMEOUT: timeout=1, timeout_idx=idx, proc_resetl=0. Terminal until reset. done stays 0.
- start outside IDLE is ignored, including in DONE/TIMEOUT; a new run needs reset.
- Counters never wrap: wd ≤ WD_LIMIT-1, pass_count ≤ NUM_PROGS.

Decomposition:
- Package proc_test_pkg holds:
  - the state enum (3-bit encoding);
  - the IDX_W function ($clog2(NUM_PROGS)+1);
  - localparam defaults for WD_LIMIT and RESET_CYCLES.
- One sub-module, proc_watchdog: WD_W-bit counter with clear/enable inputs and an `expire` output at LIMIT-1, parameterised by LIMIT.
- Table slicing and the FSM stay in the top module.

Test Plan:
- NUM_PROGS=1, end 0x34, expect 0x123456789ABCDEF0, core model reaches 0x34 at cycle 13 with matching wb_data → one result_valid with pass=1, pass_count=1, done=1, all_passed=1, timeout=0.
- NUM_PROGS=2, second expect 0x0C but wb_data=0x0B → results idx0 pass=1, idx1 pass=0, pass_count=1, done=1, all_passed=0.
- PC stuck at 0x10, WD_LIMIT=0x20 → TIMEOUT exactly 32 cycles after RUN entry, timeout_idx=0, done=0, proc_resetl=0.
- End PC reached on the same cycle wd hits LIMIT-1 → CHECK path taken, timeout=0.
- reset asserted during RUN of program 1, then start → all outputs return to reset values the cycle after; re-run begins at program 0 with prog_startpc[0] on proc_startpc.
- start pulsed while busy and again in DONE → no state change, no extra results.

Source files
------------

// File: rtl/proc_test_pkg.sv
// proc_test_pkg: shared state encoding and defaults for the processor test sequencer
package proc_test_pkg;
  typedef enum logic [2:0] {IDLE, RST, RUN, SETTLE, CHECK, DONE, TIMEOUT} state_t;
  localparam logic [15:0] WD_LIMIT_DEF = 16'h0020;
  localparam int RESET_CYCLES_DEF = 1;
  function automatic int idx_w(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/proc_watchdog.sv
// proc_watchdog: saturating run-cycle counter that flags expiry at LIMIT-1
module proc_watchdog #(
  parameter int WD_W = 16,
  parameter logic [WD_W-1:0] LIMIT = 16'h0020
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);
  logic [WD_W-1:0] count;
  assign expire = count == LIMIT - 1'b1;
  always_ff @(posedge clk)
    if (rst || clear) count <= '0;
    else if (en && !expire) count <= count + 1'b1;
endmodule

// File: rtl/proc_test_sequencer.sv
// proc_test_sequencer: runs a table of programs on the processor, checks pass codes, guards with a watchdog
module proc_test_sequencer import proc_test_pkg::*; #(
  parameter int NUM_PROGS = 4,
  parameter int PC_W = 64,
  parameter int DATA_W = 64,
  parameter int WD_W = 16,
  parameter logic [WD_W-1:0] WD_LIMIT = WD_W'(WD_LIMIT_DEF),
  parameter int RESET_CYCLES = RESET_CYCLES_DEF,
  parameter int SETTLE_CYCLES = 1,
  localparam int IDX_W = idx_w(NUM_PROGS)
) (
  input  logic                        Clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [NUM_PROGS*PC_W-1:0]   prog_startpc,
  input  logic [NUM_PROGS*PC_W-1:0]   prog_endpc,
  input  logic [NUM_PROGS*DATA_W-1:0] prog_expect,
  input  logic [PC_W-1:0]             currentpc,
  input  logic [DATA_W-1:0]           wb_data,
  output logic                        proc_resetl,
  output logic [PC_W-1:0]             proc_startpc,
  output logic                        busy,
  output logic                        result_valid,
  output logic                        result_pass,
  output logic [IDX_W-1:0]            result_idx,
  output logic [IDX_W-1:0]            pass_count,
  output logic                        done,
  output logic                        all_passed,
  output logic                        timeout,
  output logic [IDX_W-1:0]            timeout_idx
);
  localparam int SEL_W = NUM_PROGS > 1 ? $clog2(NUM_PROGS) : 1;
  localparam int RC_W = RESET_CYCLES > 1 ? $clog2(RESET_CYCLES) : 1;
  localparam int SC_W = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  state_t state;
  logic [IDX_W-1:0] idx;
  logic [RC_W-1:0] rcnt;
  logic [SC_W-1:0] scnt;
  logic [PC_W-1:0] spc [NUM_PROGS];
  logic [PC_W-1:0] epc [NUM_PROGS];
  logic [DATA_W-1:0] exd [NUM_PROGS];
  logic [SEL_W-1:0] sel, nsel;
  logic hit, pass, last, rst_end, set_end, expire, to_check;
  genvar i;
  for (i = 0; i < NUM_PROGS; i++) begin : g_tab
    assign spc[i] = prog_startpc[i*PC_W +: PC_W];
    assign epc[i] = prog_endpc[i*PC_W +: PC_W];
    assign exd[i] = prog_expect[i*DATA_W +: DATA_W];
  end
  assign sel = idx[SEL_W-1:0];
  assign nsel = SEL_W'(idx + 1'b1);
  assign hit = currentpc >= epc[sel];
  assign pass = wb_data == exd[sel];
  assign last = idx == IDX_W'(NUM_PROGS - 1);
  assign rst_end = rcnt == RC_W'(RESET_CYCLES - 1);
  assign set_end = scnt == SC_W'(SETTLE_CYCLES - 1);
  // the result is captured on the edge entering CHECK so it is visible during CHECK
  assign to_check = (state == RUN && hit && SETTLE_CYCLES == 0) || (state == SETTLE && set_end);
  proc_watchdog #(.WD_W(WD_W), .LIMIT(WD_LIMIT)) u_wd (
    .clk(Clk), .rst(reset), .clear(state == RST), .en(state == RUN), .expire(expire)
  );
  always_ff @(posedge Clk)
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      rcnt <= '0;
      scnt <= '0;
      proc_resetl <= 1'b0;
      proc_startpc <= '0;
      busy <= 1'b0;
      result_valid <= 1'b0;
      result_pass <= 1'b0;
      result_idx <= '0;
      pass_count <= '0;
      done <= 1'b0;
      all_passed <= 1'b0;
      timeout <= 1'b0;
      timeout_idx <= '0;
    end else begin
      result_valid <= 1'b0;
      result_pass <= 1'b0;
      if (to_check) begin
        result_valid <= 1'b1;
        result_pass <= pass;
        result_idx <= idx;
        if (pass) pass_count <= pass_count + 1'b1;
      end
      case (state)
        IDLE: if (start) begin
          state <= RST;
          idx <= '0;
          rcnt <= '0;
          proc_startpc <= spc[0];
          busy <= 1'b1;
        end
        RST: if (rst_end) begin
          state <= RUN;
          proc_resetl <= 1'b1;
        end else rcnt <= rcnt + 1'b1;
        RUN: if (hit) begin
          state <= (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
          scnt <= '0;
        end else if (expire) begin
          state <= TIMEOUT;
          timeout <= 1'b1;
          timeout_idx <= idx;
          proc_resetl <= 1'b0;
          busy <= 1'b0;
        end
        SETTLE: if (set_end) state <= CHECK;
          else scnt <= scnt + 1'b1;
        CHECK: if (last) begin
          state <= DONE;
          done <= 1'b1;
          all_passed <= pass_count == IDX_W'(NUM_PROGS);
          proc_resetl <= 1'b0;
          busy <= 1'b0;
        end else begin
          state <= RST;
          idx <= idx + 1'b1;
          rcnt <= '0;
          proc_startpc <= spc[nsel];
          proc_resetl <= 1'b0;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_proc_test_sequencer.sv
// tb_proc_test_sequencer: timeline model of the sequencer plus directed program-table scenarios
module tb_proc_test_sequencer;
  localparam int N = 2, R = 1, S = 1, WDL = 32;
  logic Clk = 0, reset = 1, start = 0, stuck = 0;
  logic [63:0] sp [2], ep [2], ex [2], wbv [2];
  logic [127:0] sp_v, ep_v, ex_v;
  logic [63:0] pc = 0, wb = 0, pc1 = 0;
  logic proc_resetl, busy, result_valid, result_pass, done, all_passed, timeout;
  logic [63:0] proc_startpc, spc1;
  logic [1:0] result_idx, pass_count, timeout_idx;
  logic rl1, busy1, rv1, rp1, done1, all1, to1;
  logic [0:0] ridx1, pcnt1, toidx1;
  int compared = 0, mismatched = 0;
  bit armed = 0;
  int res_q [$];
  int rl_hi = 0, pre_rv = 0, r1_cnt = 0;
  bit m_on = 0, m_fin = 0;
  int m_prog = 0, m_t = 0, m_hit = -1, e_ridx = 0, e_pc = 0, e_toidx = 0;
  logic e_resetl, e_busy, e_rv, e_rp, e_done, e_all, e_to;
  logic [63:0] e_spc;

  assign sp_v = {sp[1], sp[0]};
  assign ep_v = {ep[1], ep[0]};
  assign ex_v = {ex[1], ex[0]};
  always #5 Clk = ~Clk;

  proc_test_sequencer #(.NUM_PROGS(N), .PC_W(64), .DATA_W(64), .WD_W(16), .WD_LIMIT(16'h0020),
    .RESET_CYCLES(R), .SETTLE_CYCLES(S)) dut (
    .Clk(Clk), .reset(reset), .start(start), .prog_startpc(sp_v), .prog_endpc(ep_v),
    .prog_expect(ex_v), .currentpc(pc), .wb_data(wb), .proc_resetl(proc_resetl),
    .proc_startpc(proc_startpc), .busy(busy), .result_valid(result_valid),
    .result_pass(result_pass), .result_idx(result_idx), .pass_count(pass_count), .done(done),
    .all_passed(all_passed), .timeout(timeout), .timeout_idx(timeout_idx));

  proc_test_sequencer #(.NUM_PROGS(1), .PC_W(64), .DATA_W(64), .WD_W(16), .WD_LIMIT(16'h0020),
    .RESET_CYCLES(1), .SETTLE_CYCLES(0)) dut1 (
    .Clk(Clk), .reset(reset), .start(start), .prog_startpc(64'h0), .prog_endpc(64'h34),
    .prog_expect(64'h123456789ABCDEF0), .currentpc(pc1), .wb_data(64'h123456789ABCDEF0),
    .proc_resetl(rl1), .proc_startpc(spc1), .busy(busy1), .result_valid(rv1),
    .result_pass(rp1), .result_idx(ridx1), .pass_count(pcnt1), .done(done1),
    .all_passed(all1), .timeout(to1), .timeout_idx(toidx1));

  // processor stand-ins: PC loads startpc while held in reset, then advances by 4 per cycle
  initial forever begin
    @(negedge Clk);
    pc = !proc_resetl ? proc_startpc : stuck ? pc : pc + 64'd4;
    wb = (proc_startpc == sp[1]) ? wbv[1] : wbv[0];
    pc1 = !rl1 ? spc1 : pc1 + 64'd4;
  end

  task automatic launch(input int p, input int t0);
    m_on = 1; m_prog = p; m_t = t0; m_hit = -1; e_spc = sp[p]; e_busy = 1;
  endtask

  // m_t is the cycle index within the current program; the first R cycles hold the core in reset
  initial forever begin
    @(posedge Clk);
    if (reset) begin
      m_on = 0; m_fin = 0; e_resetl = 0; e_spc = 0; e_busy = 0; e_rv = 0; e_rp = 0;
      e_ridx = 0; e_pc = 0; e_done = 0; e_all = 0; e_to = 0; e_toidx = 0;
    end else begin
      e_rv = 0;
      if (m_on) begin
        if (m_t >= R && m_hit < 0) begin
          if (pc >= ep[m_prog]) m_hit = m_t;
          else if (m_t - R == WDL - 1) begin
            m_on = 0; m_fin = 1; e_to = 1; e_toidx = m_prog; e_busy = 0;
          end
        end
        if (m_on && m_hit >= 0 && m_t == m_hit + S) begin
          e_rv = 1; e_rp = (wb == ex[m_prog]); e_ridx = m_prog; e_pc += int'(e_rp);
        end
        if (m_on && m_hit >= 0 && m_t == m_hit + S + 1) begin
          if (m_prog == N - 1) begin
            m_on = 0; m_fin = 1; e_done = 1; e_all = (e_pc == N); e_busy = 0;
          end else launch(m_prog + 1, -1);
        end
        m_t++;
      end else if (!m_fin && start) launch(0, 0);
      e_resetl = m_on && m_t >= R;
    end
  end

  initial forever begin
    @(negedge Clk);
    if (armed) begin
      compared++;
      if (proc_resetl !== e_resetl || proc_startpc !== e_spc || busy !== e_busy ||
          result_valid !== e_rv || (e_rv && (result_pass !== e_rp || result_idx !== 2'(e_ridx))) ||
          pass_count !== 2'(e_pc) || done !== e_done || all_passed !== e_all ||
          timeout !== e_to || timeout_idx !== 2'(e_toidx)) begin
        mismatched++;
        $display("FAIL cycle t=%0t got rl=%b spc=%h busy=%b rv=%b rp=%b ridx=%0d pc=%0d done=%b all=%b to=%b toidx=%0d want rl=%b spc=%h busy=%b rv=%b rp=%b ridx=%0d pc=%0d done=%b all=%b to=%b toidx=%0d",
          $time, proc_resetl, proc_startpc, busy, result_valid, result_pass, result_idx, pass_count,
          done, all_passed, timeout, timeout_idx, e_resetl, e_spc, e_busy, e_rv, e_rp, e_ridx, e_pc,
          e_done, e_all, e_to, e_toidx);
      end
    end
  end

  initial forever begin
    @(negedge Clk);
    if (reset) begin
      res_q.delete(); rl_hi = 0; pre_rv = 0; r1_cnt = 0;
    end else begin
      if (busy && !result_valid && res_q.size() == 0) pre_rv++;
      if (result_valid) res_q.push_back(int'(result_idx) * 2 + int'(result_pass));
      if (proc_resetl) rl_hi++;
      if (rv1 && rp1 && ridx1 == 1'b0) r1_cnt++;
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1; start = 0;
    repeat (2) @(negedge Clk);
    reset = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge Clk);
    start = 0;
  endtask

  task automatic wait_end(input string nm);
    int n = 0;
    while (!(done || timeout) && n < 400) begin
      @(negedge Clk);
      n++;
    end
    check({nm, "_finished"}, 64'(done | timeout), 64'd1);
    repeat (4) @(negedge Clk);
  endtask

  initial begin
    sp[0] = 64'h0;   ep[0] = 64'h34;  ex[0] = 64'h123456789ABCDEF0; wbv[0] = 64'h123456789ABCDEF0;
    sp[1] = 64'h100; ep[1] = 64'h120; ex[1] = 64'hC;               wbv[1] = 64'hC;
    @(negedge Clk);
    armed = 1;
    do_reset();
    check("rst_resetl", 64'(proc_resetl), 0);
    check("rst_startpc", proc_startpc, 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    // two passing programs, with start pulses while busy and after done
    pulse_start();
    repeat (3) @(negedge Clk);
    pulse_start();
    wait_end("s1");
    pulse_start();
    repeat (5) @(negedge Clk);
    check("s1_nres", res_q.size(), 2);
    check("s1_res0", res_q[0], 1);
    check("s1_res1", res_q[1], 3);
    check("s1_pcount", 64'(pass_count), 2);
    check("s1_allpass", 64'(all_passed), 1);
    check("s1_timeout", 64'(timeout), 0);
    check("s1_latency", pre_rv, 15);
    check("s1_resetl", 64'(proc_resetl), 0);
    check("one_done", 64'(done1), 1);
    check("one_allpass", 64'(all1), 1);
    check("one_pcount", 64'(pcnt1), 1);
    check("one_timeout", 64'(to1 | toidx1 | busy1), 0);
    check("one_results", r1_cnt, 1);
    // second program's pass code differs
    wbv[1] = 64'hB;
    do_reset(); pulse_start(); wait_end("s2");
    check("s2_nres", res_q.size(), 2);
    check("s2_res0", res_q[0], 1);
    check("s2_res1", res_q[1], 2);
    check("s2_pcount", 64'(pass_count), 1);
    check("s2_allpass", 64'(all_passed), 0);
    check("s2_done", 64'(done), 1);
    // PC stuck below the end PC
    wbv[1] = 64'hC; sp[0] = 64'h10; ep[0] = 64'h1000; stuck = 1;
    do_reset(); pulse_start(); wait_end("s3");
    check("s3_timeout", 64'(timeout), 1);
    check("s3_toidx", 64'(timeout_idx), 0);
    check("s3_done", 64'(done), 0);
    check("s3_resetl", 64'(proc_resetl), 0);
    check("s3_run_cycles", rl_hi, 32);
    check("s3_nres", res_q.size(), 0);
    // end PC reached on the very cycle the watchdog would expire
    stuck = 0; sp[0] = 64'h0; ep[0] = 64'h80;
    do_reset(); pulse_start(); wait_end("s4");
    check("s4_timeout", 64'(timeout), 0);
    check("s4_done", 64'(done), 1);
    check("s4_nres", res_q.size(), 2);
    // end PC one cycle too late on program 1
    ep[0] = 64'h34; ep[1] = 64'h184;
    do_reset(); pulse_start(); wait_end("s5");
    check("s5_timeout", 64'(timeout), 1);
    check("s5_toidx", 64'(timeout_idx), 1);
    check("s5_nres", res_q.size(), 1);
    check("s5_pcount", 64'(pass_count), 1);
    check("s5_done", 64'(done), 0);
    // reset in the middle of program 1, then restart
    ep[1] = 64'h120; sp[0] = 64'h8;
    do_reset(); pulse_start();
    begin
      int n = 0;
      while (!(proc_startpc == sp[1] && proc_resetl) && n < 200) begin
        @(negedge Clk);
        n++;
      end
      check("s6_reach_prog1", 64'(n < 200), 1);
    end
    repeat (2) @(negedge Clk);
    reset = 1;
    @(negedge Clk);
    check("s6_rst_resetl", 64'(proc_resetl), 0);
    check("s6_rst_startpc", proc_startpc, 0);
    check("s6_rst_busy", 64'(busy), 0);
    check("s6_rst_rv", 64'(result_valid), 0);
    check("s6_rst_pcount", 64'(pass_count), 0);
    @(negedge Clk);
    reset = 0;
    pulse_start();
    check("s6_startpc", proc_startpc, 64'h8);
    check("s6_resetl", 64'(proc_resetl), 0);
    check("s6_busy", 64'(busy), 1);
    wait_end("s6");
    check("s6_done", 64'(done), 1);
    check("s6_pcount", 64'(pass_count), 2);
    check("s6_allpass", 64'(all_passed), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
